noc_router_sync: RTL

- Clocked, parametrised successor to the five-port asynchronous mesh router.
- Port order is fixed: 0 North, 1 East, 2 South, 3 West, 4 Local/resource.
- Each input has a FIFO of configurable depth. Routing is XY dimension-ordered and switching is wormhole. Each output has a round-robin arbiter and a registered valid/ready stage.
- It is the mesh tile used when the NoC is built on one synchronous clock instead of the bundled-data latch pipeline.

---
 rtl/noc_router_sync.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/noc_router_sync.sv
// Five-port synchronous mesh router tile: per-input FIFOs, XY routing,
// wormhole switching and a round-robin arbiter with a registered stage per output.
module noc_router_sync #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned COORD_W    = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned X_ID       = 0,
    parameter int unsigned Y_ID       = 0
) (
    input  logic                      clk,
    input  logic                      preset,
    input  logic [4:0]                in_valid,
    input  logic [5*(DATA_W+2)-1:0]   in_flit,
    output logic [4:0]                in_ready,
    output logic [4:0]                out_valid,
    output logic [5*(DATA_W+2)-1:0]   out_flit,
    input  logic [4:0]                out_ready
);

    localparam int unsigned FLIT_W = DATA_W + 2;
    localparam int unsigned NP     = 5;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    localparam logic [2:0] P_N = 3'd0;
    localparam logic [2:0] P_E = 3'd1;
    localparam logic [2:0] P_S = 3'd2;
    localparam logic [2:0] P_W = 3'd3;
    localparam logic [2:0] P_L = 3'd4;

    typedef enum logic {ST_IDLE, ST_LOCKED} ost_t;

    logic [FLIT_W-1:0]      mem [NP][FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr [NP];
    logic [PTR_W-1:0]       rd_ptr [NP];
    logic [CNT_W-1:0]       cnt [NP];
    logic [FLIT_W-1:0]      head_flit [NP];
    logic [2:0]             rc [NP];
    logic [2:0]             route_reg [NP];
    logic [NP-1:0]          nonempty;
    logic [NP-1:0]          push;
    logic [NP-1:0]          pop;
    logic [NP-1:0][NP-1:0]  hreq;

    ost_t                   ost [NP];
    logic [2:0]             owner [NP];
    logic [2:0]             last_grant [NP];
    logic [NP-1:0]          gnt_vld;
    logic [NP-1:0]          fire;
    logic [2:0]             gnt_idx [NP];

    // XY dimension-ordered route: X first, then Y, else local
    function automatic logic [2:0] xy_route(input logic [COORD_W-1:0] dx,
                                            input logic [COORD_W-1:0] dy);
        logic [2:0] r;
        if (dx > COORD_W'(X_ID))      r = P_E;
        else if (dx < COORD_W'(X_ID)) r = P_W;
        else if (dy > COORD_W'(Y_ID)) r = P_S;
        else if (dy < COORD_W'(Y_ID)) r = P_N;
        else                          r = P_L;
        return r;
    endfunction

    // Round-robin pick starting after last; returns {valid, index}
    function automatic logic [3:0] rr_pick(input logic [NP-1:0] req, input logic [2:0] last);
        logic [3:0] r;
        logic [2:0] idx;
        r = '0;
        for (int k = NP; k >= 1; k--) begin
            idx = 3'((32'(last) + 32'(k)) % NP);
            if (req[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            nonempty[i]  = cnt[i] != '0;
            in_ready[i]  = cnt[i] != CNT_W'(FIFO_DEPTH);
            push[i]      = in_valid[i] && in_ready[i];
            head_flit[i] = mem[i][rd_ptr[i]];
            rc[i]        = xy_route(head_flit[i][COORD_W-1:0], head_flit[i][2*COORD_W-1:COORD_W]);
        end
    end

    // hreq[o][i]: input i presents a head flit routed to output o
    always_comb begin
        hreq = '0;
        for (int o = 0; o < NP; o++)
            for (int i = 0; i < NP; i++)
                hreq[o][i] = nonempty[i] && head_flit[i][FLIT_W-1] && (rc[i] == 3'(o));
    end

    always_comb begin
        gnt_vld = '0;
        fire    = '0;
        pop     = '0;
        for (int o = 0; o < NP; o++) begin
            gnt_idx[o] = '0;
            if (ost[o] == ST_LOCKED) begin
                gnt_vld[o] = nonempty[owner[o]] && !head_flit[owner[o]][FLIT_W-1] &&
                             (route_reg[owner[o]] == 3'(o));
                gnt_idx[o] = owner[o];
            end else begin
                {gnt_vld[o], gnt_idx[o]} = rr_pick(hreq[o], last_grant[o]);
            end
            fire[o] = gnt_vld[o] && (!out_valid[o] || out_ready[o]);
            if (fire[o]) pop[gnt_idx[o]] = 1'b1;
        end
    end

    // FIFO storage carries no reset; validity is tracked by cnt
    always_ff @(posedge clk) begin
        for (int i = 0; i < NP; i++)
            if (push[i]) mem[i][wr_ptr[i]] <= in_flit[i*FLIT_W +: FLIT_W];
    end

    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < NP; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                cnt[i] <= cnt[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
        end
    end

    // Per-output allocation FSM and registered output stage
    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            out_valid <= '0;
            out_flit  <= '0;
            for (int o = 0; o < NP; o++) begin
                ost[o]        <= ST_IDLE;
                owner[o]      <= '0;
                last_grant[o] <= 3'(NP - 1);
                route_reg[o]  <= '0;
            end
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (fire[o]) begin
                    out_valid[o]                  <= 1'b1;
                    out_flit[o*FLIT_W +: FLIT_W]  <= head_flit[gnt_idx[o]];
                    if (ost[o] == ST_IDLE) begin
                        last_grant[o]          <= gnt_idx[o];
                        route_reg[gnt_idx[o]]  <= 3'(o);
                        if (!head_flit[gnt_idx[o]][FLIT_W-2]) begin
                            ost[o]   <= ST_LOCKED;
                            owner[o] <= gnt_idx[o];
                        end
                    end else if (head_flit[gnt_idx[o]][FLIT_W-2]) begin
                        ost[o] <= ST_IDLE;
                    end
                end else if (out_ready[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
        end
    end

endmodule
